// File: rtl/motion_step_gen_pkg.sv
// Shared types and constants for the two-axis step/direction generator.
package motion_step_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } axisState_t;

  localparam int unsigned SPEED_MAX = 15;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  // Clamp a raw register-file speed word to the 4-bit speed range.
  function automatic logic [3:0] satSpeed(input logic [31:0] speed);
    return (speed > 32'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed[3:0];
  endfunction

endpackage

// File: rtl/motion_step_gen_if.sv
// Register-file side inputs and STEP/DIR/position outputs of the motion block.
interface motion_step_gen_if #(
  parameter int unsigned POS_W = 16
);
  logic [31:0]             xSpeed;
  logic [31:0]             xDirection;
  logic [31:0]             ySpeed;
  logic [31:0]             yDirection;
  logic                    pos_clear;
  logic                    x_step;
  logic                    x_dir;
  logic signed [POS_W-1:0] x_pos;
  logic                    x_limit;
  logic                    y_step;
  logic                    y_dir;
  logic signed [POS_W-1:0] y_pos;
  logic                    y_limit;

  modport master (
    output xSpeed, xDirection, ySpeed, yDirection, pos_clear,
    input  x_step, x_dir, x_pos, x_limit, y_step, y_dir, y_pos, y_limit
  );

  modport slave (
    input  xSpeed, xDirection, ySpeed, yDirection, pos_clear,
    output x_step, x_dir, x_pos, x_limit, y_step, y_dir, y_pos, y_limit
  );
endinterface

// File: rtl/motion_step_gen_axis.sv
// One axis: speed/direction sampling, step FSM with shared countdown, and
// a saturating signed position counter.
module step_axis
  import motion_step_gen_pkg::*;
#(
  parameter int unsigned PERIOD_UNIT = 1000,
  parameter int unsigned PULSE_W     = 50,
  parameter int unsigned DIR_SETUP   = 100,
  parameter int unsigned POS_W       = 16
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic [31:0]             speed,
  input  logic [31:0]             direction,
  input  logic                    posClear,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] pos,
  output logic                    limit
);

  localparam int unsigned CNT_W = $clog2(PERIOD_UNIT * (SPEED_MAX + 1) + DIR_SETUP + 1);
  localparam logic signed [POS_W-1:0] POS_HI = POS_W'((1 << (POS_W - 1)) - 1);
  localparam logic signed [POS_W-1:0] POS_LO = -POS_HI;

  logic [3:0]              spdReg;
  logic                    dirReg;
  axisState_t              state, stateNext;
  logic [CNT_W-1:0]        cnt, cntNext;
  logic [CNT_W-1:0]        period, periodNext;
  logic                    stepNext, dirNext, limitNext;
  logic signed [POS_W-1:0] posNext;
  logic                    decide, attempt, atBound;

  logic unusedDirHi;
  assign unusedDirHi = ^direction[31:1];

  assign atBound = (dir == DIR_POS) ? (pos == POS_HI) : (pos == POS_LO);

  // Input sample, FSM state and all registered outputs.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      spdReg <= '0;
      dirReg <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      period <= '0;
      step   <= 1'b0;
      dir    <= DIR_NEG;
      pos    <= '0;
      limit  <= 1'b0;
    end else begin
      spdReg <= satSpeed(speed);
      dirReg <= direction[0];
      state  <= stateNext;
      cnt    <= cntNext;
      period <= periodNext;
      step   <= stepNext;
      dir    <= dirNext;
      pos    <= posNext;
      limit  <= limitNext;
    end
  end

  // Next-state logic: decision points feed a common step-attempt path.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    periodNext = period;
    stepNext   = step;
    dirNext    = dir;
    posNext    = pos;
    limitNext  = limit;
    decide     = 1'b0;
    attempt    = 1'b0;

    case (state)
      IDLE:  decide = 1'b1;
      SETUP: begin
        if (cnt == '0) attempt = 1'b1;
        else           cntNext = cnt - CNT_W'(1);
      end
      PULSE: begin
        if (cnt == '0) begin
          stateNext = GAP;
          stepNext  = 1'b0;
          cntNext   = period - CNT_W'(PULSE_W + 1);
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) decide = 1'b1;
        else           cntNext = cnt - CNT_W'(1);
      end
      default: stateNext = IDLE;
    endcase

    if (decide) begin
      if (spdReg == '0) begin
        stateNext = IDLE;
      end else if (dirReg != dir) begin
        dirNext   = dirReg;
        cntNext   = CNT_W'(DIR_SETUP - 1);
        stateNext = SETUP;
      end else begin
        attempt = 1'b1;
      end
    end

    // A blocked step parks the axis in IDLE with the limit flag raised.
    if (attempt) begin
      if (atBound) begin
        limitNext = 1'b1;
        stateNext = IDLE;
      end else begin
        stateNext  = PULSE;
        stepNext   = 1'b1;
        cntNext    = CNT_W'(PULSE_W - 1);
        posNext    = (dir == DIR_POS) ? pos + POS_W'(1) : pos - POS_W'(1);
        limitNext  = 1'b0;
        periodNext = CNT_W'(PERIOD_UNIT * (SPEED_MAX + 1 - 32'(spdReg)));
      end
    end

    if (posClear) begin
      posNext   = '0;
      limitNext = 1'b0;
    end
  end

endmodule

// File: rtl/motion_step_gen.sv
// Two-axis STEP/DIR generator; each axis is an independent step_axis instance.
module motion_step_gen #(
  parameter int unsigned PERIOD_UNIT = 1000,
  parameter int unsigned PULSE_W     = 50,
  parameter int unsigned DIR_SETUP   = 100,
  parameter int unsigned POS_W       = 16
) (
  input logic               clock,
  input logic               ctrl_reset,
  motion_step_gen_if.slave  bus
);

  step_axis #(
    .PERIOD_UNIT(PERIOD_UNIT), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .POS_W(POS_W)
  ) xAxis (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .speed      (bus.xSpeed),
    .direction  (bus.xDirection),
    .posClear   (bus.pos_clear),
    .step       (bus.x_step),
    .dir        (bus.x_dir),
    .pos        (bus.x_pos),
    .limit      (bus.x_limit)
  );

  step_axis #(
    .PERIOD_UNIT(PERIOD_UNIT), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .POS_W(POS_W)
  ) yAxis (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .speed      (bus.ySpeed),
    .direction  (bus.yDirection),
    .posClear   (bus.pos_clear),
    .step       (bus.y_step),
    .dir        (bus.y_dir),
    .pos        (bus.y_pos),
    .limit      (bus.y_limit)
  );

endmodule

// File: tb/tb_motion_step_gen.sv
// Scoreboard bench: an event-level axis model predicts every STEP rise
// (cycle, direction, position); a monitor matches DUT rises against it.
module tb_motion_step_gen;

  localparam int PU = 4;
  localparam int PW = 2;
  localparam int DS = 3;
  localparam int PWID = 8;
  localparam int POS_MAX = 127;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;

  motion_step_gen_if #(.POS_W(PWID)) bus();

  motion_step_gen #(
    .PERIOD_UNIT(PU), .PULSE_W(PW), .DIR_SETUP(DS), .POS_W(PWID)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  typedef struct {
    int   cyc;
    logic dir;
    int   pos;
  } stepEv_t;

  stepEv_t xQ[$];
  stepEv_t yQ[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state per axis (0 = X, 1 = Y)
  int   mSpd[2];
  int   mPos[2];
  int   nextDec[2];
  logic mDirIn[2];
  logic mDir[2];
  logic mLimit[2];
  logic pending[2];

  initial begin
    #50;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input logic [31:0] v);
    return (v > 32'd15) ? 15 : int'(v);
  endfunction

  // A step attempt: blocked at a bound, or a pulse whose next decision is one period later.
  task automatic attempt(input int a);
    stepEv_t e;
    pending[a] = 1'b0;
    if (mDir[a] ? (mPos[a] == POS_MAX) : (mPos[a] == -POS_MAX)) begin
      mLimit[a] = 1'b1;
      nextDec[a] = cyc + 1;
    end else begin
      mPos[a] = mPos[a] + (mDir[a] ? 1 : -1);
      mLimit[a] = 1'b0;
      nextDec[a] = cyc + PU * (16 - mSpd[a]);
      if (bus.pos_clear) mPos[a] = 0;
      e.cyc = cyc;
      e.dir = mDir[a];
      e.pos = mPos[a];
      if (a == 0) xQ.push_back(e);
      else        yQ.push_back(e);
    end
  endtask

  // Model: evaluated once per rising edge using the pre-edge inputs.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      for (int a = 0; a < 2; a++) begin
        if (!ctrl_reset) begin
          mSpd[a] = 0; mDirIn[a] = 1'b0; mDir[a] = 1'b0; mPos[a] = 0;
          mLimit[a] = 1'b0; pending[a] = 1'b0; nextDec[a] = cyc + 1;
        end else begin
          if (cyc == nextDec[a]) begin
            if (pending[a]) attempt(a);
            else if (mSpd[a] == 0) nextDec[a] = cyc + 1;
            else if (mDirIn[a] != mDir[a]) begin
              mDir[a] = mDirIn[a];
              pending[a] = 1'b1;
              nextDec[a] = cyc + DS;
            end else attempt(a);
          end
          if (bus.pos_clear) begin
            mPos[a] = 0;
            mLimit[a] = 1'b0;
          end
          mSpd[a]   = sat(a == 0 ? bus.xSpeed : bus.ySpeed);
          mDirIn[a] = (a == 0) ? bus.xDirection[0] : bus.yDirection[0];
        end
      end
    end
  end

  // Monitor: every STEP rise pops one expected event; every fall checks width.
  initial begin
    logic    prev[2];
    logic    s;
    int      rise[2];
    string   ax;
    stepEv_t e;
    prev[0] = 1'b0; prev[1] = 1'b0;
    rise[0] = -1;   rise[1] = -1;
    forever begin
      @(negedge clock);
      for (int a = 0; a < 2; a++) begin
        s  = (a == 0) ? bus.x_step : bus.y_step;
        ax = (a == 0) ? "x" : "y";
        if (!ctrl_reset) begin
          prev[a] = 1'b0;
          rise[a] = -1;
        end else begin
          if (s && !prev[a]) begin
            rise[a] = cyc;
            if ((a == 0 ? xQ.size() : yQ.size()) == 0) begin
              total++;
              bad++;
              $display("FAIL %s_unexpected_step: rise at cycle %0d, none expected", ax, cyc);
            end else begin
              e = (a == 0) ? xQ.pop_front() : yQ.pop_front();
              check({ax, "_rise_cycle"}, cyc, e.cyc);
              check({ax, "_rise_dir"}, int'(a == 0 ? bus.x_dir : bus.y_dir), int'(e.dir));
              check({ax, "_rise_pos"}, int'(a == 0 ? bus.x_pos : bus.y_pos), e.pos);
            end
          end else if (!s && prev[a] && rise[a] >= 0) begin
            check({ax, "_pulse_width"}, cyc - rise[a], PW);
          end
          prev[a] = s;
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic setX(input logic [31:0] s, input logic [31:0] d);
    bus.xSpeed = s;
    bus.xDirection = d;
  endtask

  task automatic setY(input logic [31:0] s, input logic [31:0] d);
    bus.ySpeed = s;
    bus.yDirection = d;
  endtask

  // Bounded wait at falling edges for sel (0:x_step 1:y_step 2:x_dir) to equal val.
  task automatic waitSig(input int sel, input logic val, input int maxCyc, input string name);
    logic v;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clock);
      v = (sel == 0) ? bus.x_step : (sel == 1) ? bus.y_step : bus.x_dir;
      if (v == val) return;
    end
    total++;
    bad++;
    $display("FAIL %s: timeout after %0d cycles waiting for %0d", name, maxCyc, val);
  endtask

  function automatic logic [31:0] randSpeed();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'($urandom_range(16, 100));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c0;
    int p0;
    setX(0, 0);
    setY(0, 0);
    bus.pos_clear = 1'b0;

    // Reset with no clock running
    #2 ctrl_reset = 1'b0;
    #10;
    check("rst_x_step", int'(bus.x_step), 0);
    check("rst_x_dir", int'(bus.x_dir), 0);
    check("rst_x_pos", int'(bus.x_pos), 0);
    check("rst_x_limit", int'(bus.x_limit), 0);
    check("rst_y_step", int'(bus.y_step), 0);
    check("rst_y_dir", int'(bus.y_dir), 0);
    check("rst_y_pos", int'(bus.y_pos), 0);
    check("rst_y_limit", int'(bus.y_limit), 0);
    run(2);
    ctrl_reset = 1'b1;
    run(50);
    check("idle_x_pos", int'(bus.x_pos), 0);
    check("idle_y_pos", int'(bus.y_pos), 0);

    // X forward at speed 12: period 16, five pulses in 80 cycles
    setX(12, 1);
    run(80);
    check("fwd_x_dir", int'(bus.x_dir), 1);
    check("fwd_x_pos", int'(bus.x_pos), 5);
    check("fwd_y_pos", int'(bus.y_pos), 0);

    // Y speed saturates to 15: STEP pattern 1,1,0,0
    setY(40, 1);
    waitSig(1, 1'b1, 20, "sat_y_first_rise");
    waitSig(1, 1'b0, 10, "sat_y_fall");
    waitSig(1, 1'b1, 10, "sat_y_rise");
    check("sat_y_pat0", int'(bus.y_step), 1);
    run(1); check("sat_y_pat1", int'(bus.y_step), 1);
    run(1); check("sat_y_pat2", int'(bus.y_step), 0);
    run(1); check("sat_y_pat3", int'(bus.y_step), 0);
    run(1); check("sat_y_pat4", int'(bus.y_step), 1);
    run(20);
    check("sat_y_pos", int'(bus.y_pos), mPos[1]);

    // X reversal: STEP follows the DIR change by DIR_SETUP cycles
    setX(12, 0);
    waitSig(2, 1'b0, 40, "rev_x_dir_fall");
    c0 = cyc;
    waitSig(0, 1'b1, 10, "rev_x_rise");
    check("rev_setup_delay", cyc - c0, DS);
    run(40);
    check("rev_x_limit", int'(bus.x_limit), 0);
    check("rev_x_pos", int'(bus.x_pos), mPos[0]);

    // Drive X into the positive bound, then back off
    setY(0, 1);
    setX(15, 1);
    run(700);
    check("lim_x_pos", int'(bus.x_pos), POS_MAX);
    check("lim_x_limit", int'(bus.x_limit), 1);
    check("lim_x_step", int'(bus.x_step), 0);
    setX(15, 0);
    run(6);
    check("unlim_x_pos", int'(bus.x_pos), POS_MAX - 1);
    check("unlim_x_limit", int'(bus.x_limit), 0);

    // Asynchronous reset in the middle of a pulse
    waitSig(0, 1'b1, 20, "arst_wait_pulse");
    #2 ctrl_reset = 1'b0;
    #1;
    check("arst_x_step", int'(bus.x_step), 0);
    check("arst_x_pos", int'(bus.x_pos), 0);
    check("arst_x_dir", int'(bus.x_dir), 0);
    run(3);
    ctrl_reset = 1'b1;
    c0 = cyc;
    waitSig(0, 1'b1, 10, "arst_resume");
    check("arst_latency", cyc - c0, 2);

    // Speed 0 during GAP: that gap completes and no further pulses follow
    setX(12, 0);
    run(20);
    waitSig(0, 1'b0, 20, "stop_fall");
    waitSig(0, 1'b1, 20, "stop_rise");
    run(4);
    setX(0, 0);
    p0 = mPos[0];
    run(60);
    check("stop_x_step", int'(bus.x_step), 0);
    check("stop_x_pos", int'(bus.x_pos), p0);

    // Randomized phases with occasional position clears
    for (int it = 0; it < 30; it++) begin
      setX(randSpeed(), $urandom);
      setY(randSpeed(), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        run($urandom_range(1, 30));
        bus.pos_clear = 1'b1;
        run(1);
        bus.pos_clear = 1'b0;
      end
      run($urandom_range(5, 60));
      check("rnd_x_pos", int'(bus.x_pos), mPos[0]);
      check("rnd_y_pos", int'(bus.y_pos), mPos[1]);
      check("rnd_x_limit", int'(bus.x_limit), int'(mLimit[0]));
      check("rnd_y_limit", int'(bus.y_limit), int'(mLimit[1]));
    end

    // Drain: every predicted step must have been observed
    setX(0, 0);
    setY(0, 0);
    run(150);
    check("drain_x_queue", xQ.size(), 0);
    check("drain_y_queue", yQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
